magicball_answer_fsm: RTL
=========================

# magicball_answer_fsm

Downstream consumer of the xorshift PRNG's `current_prn_o`. It debounces the physical "shake" button, also accepts a software shake from the OBI bus, and runs a shake animation period. It then samples the PRN, maps it onto one of `NUM_ANSWERS` answer indices, and holds the answer for display. The display driver and the CPU use its outputs; the CPU reads status and answer over an OBI slave port on the user-domain bus.

## Interface
- `NUM_ANSWERS`, 20: number of answers; range 2..65535.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable-high cycles needed to accept a press; ≥1.
- `SHAKE_CYCLES`, 1000000: length of the SHAKE state; ≥1.
- `HOLD_CYCLES`, 5000000: length of the HOLD state; ≥1.
- `ID_WIDTH_OBI`, `SbrObiCfg.IdWidth`: OBI ID width.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `button_i` in 1: raw, asynchronous, active-high shake button.
- `prn_i` in 32: current PRN from the xorshift block.
- `req_i` in 1, `we_i` in 1, `be_i` in 4, `addr_i` in 32, `wdata_i` in 32, `aid_i` in ID_WIDTH_OBI: OBI request.
- `gnt_o` out 1, `rvalid_o` out 1, `rdata_o` out 32, `rid_o` out ID_WIDTH_OBI, `err_o` out 1: OBI response.
- `shaking_o` out 1: high during SHAKE.
- `answer_valid_o` out 1: high during HOLD.
- `answer_idx_o` out 16: last computed answer index.

## Operation
- **Button input path**
  - `button_i` passes through a 2-flop synchronizer.
  - A debounce counter increments while the synchronized level is 1 and clears to 0 when it is 0.
  - A press is accepted when the counter reaches `DEBOUNCE_CYCLES`. This is a one-cycle `hw_trig` pulse.
  - The counter saturates until release, so one hold produces exactly one trigger.
- **Software trigger**: an OBI write to offset 0x0 (any `wdata`, any `be`) produces a one-cycle `sw_trig` in the accept cycle.
- **Combined trigger**: `trig = hw_trig | sw_trig`. Simultaneous triggers count as one.
- **FSM** (2-bit encoding: IDLE=0, SHAKE=1, REVEAL=2, HOLD=3):
  - IDLE: on `trig`, go to SHAKE, clear the phase counter, and increment `shake_cnt`.
  - SHAKE: `shaking_o`=1. After `SHAKE_CYCLES` cycles, go to REVEAL. `trig` is ignored, not queued, and not counted.
  - REVEAL: one cycle. Computes `answer_idx_o <= (prn_i[15:0] * NUM_ANSWERS) >> 16`. The product is 32 bits; the result is always < `NUM_ANSWERS`. Then go to HOLD.
  - HOLD: `answer_valid_o`=1 for `HOLD_CYCLES` cycles, then go to IDLE. A `trig` in HOLD restarts: go to SHAKE, clear the counter, increment `shake_cnt`.
- **`answer_idx_o`** retains its value after HOLD ends.
- **`shake_cnt`** is 16 bits and wraps from 0xFFFF to 0x0000.
- **OBI register map**, decoded on `addr_i[3:2]`:
  - 0x0 CTRL: write-only trigger.
  - 0x4 STATUS: read-only. Bits [1:0] = state; bit 2 = synchronized button level; bits [31:16] = `shake_cnt`; all other bits 0.
  - 0x8 ANSWER: read-only. Bits [15:0] = `answer_idx_o`; bit 31 = `answer_valid_o`; all other bits 0.
  - 0xC: reserved.
- **OBI errors**: any read of 0x0, any write to 0x4/0x8, and any access to 0xC give `err_o`=1. `rdata` is 0 and no side effect occurs. A write to 0x0 with a live FSM is never an error, even when the trigger is ignored.

## Timing
- **Reset values**: all outputs 0, state IDLE, counters 0, synchronizer 0, `answer_idx_o`=0, `gnt_o`=`req_i` (combinational).
- **Reset mid-operation**: returns to IDLE asynchronously, with no answer update and no pending response.
- **OBI handshake**:
  - `gnt_o`=`req_i` at all times.
  - Exactly one response per granted request, on the next cycle: `rvalid_o`=1 for 1 cycle, with `rid_o` = the latched `aid_i`.
  - `rdata_o`/`err_o` are valid only with `rvalid_o` and 0 otherwise.
  - Read data reflects register state at the response cycle.
  - Back-to-back requests get back-to-back responses.
- **Software trigger latency**: write accepted in cycle T → state=SHAKE and `shaking_o`=1 from T+1, for `SHAKE_CYCLES` cycles.
  - REVEAL is at T+1+`SHAKE_CYCLES` and samples `prn_i` in that cycle.
  - `answer_valid_o`=1 and the new `answer_idx_o` appear from T+2+`SHAKE_CYCLES`, for exactly `HOLD_CYCLES` cycles.
- **Button latency**: 2 synchronizer cycles + `DEBOUNCE_CYCLES` to `hw_trig`; SHAKE starts on the following cycle.

## Test plan
(Parameters: `NUM_ANSWERS`=20, `DEBOUNCE_CYCLES`=4, `SHAKE_CYCLES`=8, `HOLD_CYCLES`=16.)
- **Reset/readout**: after reset, read 0x4 → 0x00000000 and read 0x8 → 0x00000000, each with `rvalid` 1 cycle later and `err`=0.
- **Software shake**: `prn_i`=0xDEADBEEF, write 0x0 at T.
  - `shaking_o` is high for T+1..T+8.
  - `answer_valid_o` is high for T+10..T+25 with `answer_idx_o`=14.
  - Read 0x8 during HOLD → 0x8000000E.
  - Read 0x4 after HOLD → 0x00010000.
- **Debounce**:
  - 3-cycle button glitches → no trigger, state stays IDLE.
  - Hold high for 40 cycles → exactly one shake, `shake_cnt`=1.
  - Release and press again → `shake_cnt`=2.
- **Ignored and restart triggers**:
  - A write to 0x0 during SHAKE → `err`=0, timing unchanged, `shake_cnt` unchanged.
  - A write during HOLD → SHAKE the next cycle, `answer_valid_o` drops, `shake_cnt` increments.
- **OBI errors**: read 0x0, write 0x4, write 0x8, and read 0xC each → `err_o`=1, `rdata`=0, state unchanged, `rid_o` = the issued `aid`.
- **Boundary cases**:
  - `prn_i[15:0]`=0xFFFF → idx 19.
  - `prn_i[15:0]`=0x0000 → idx 0.
  - `shake_cnt` preloaded by 65536 shakes → wraps to 0.
  - Async `rst_i` asserted during SHAKE → state IDLE immediately, all outputs 0.

Source files
------------

// File: rtl/magicball_answer_fsm.sv
// Magic-8-ball answer sequencer. A debounced button or an OBI write starts a shake.
// After the shake it samples the PRN, scales it to an answer index and holds it for display.
module magicball_answer_fsm #(
  parameter int unsigned NUM_ANSWERS     = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SHAKE_CYCLES    = 1000000,
  parameter int unsigned HOLD_CYCLES     = 5000000,
  parameter int unsigned ID_WIDTH_OBI    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    button_i,
  input  logic [31:0]             prn_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [31:0]             addr_i,
  input  logic [31:0]             wdata_i,
  input  logic [ID_WIDTH_OBI-1:0] aid_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [31:0]             rdata_o,
  output logic [ID_WIDTH_OBI-1:0] rid_o,
  output logic                    err_o,
  output logic                    shaking_o,
  output logic                    answer_valid_o,
  output logic [15:0]             answer_idx_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PH_MAX = (SHAKE_CYCLES > HOLD_CYCLES) ? SHAKE_CYCLES : HOLD_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [DB_W-1:0] DB_FULL    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] SHAKE_LAST = PH_W'(SHAKE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHAKE  = 2'd1,
    ST_REVEAL = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e                  state_reg;
  logic [PH_W-1:0]         phase_reg;
  logic [15:0]             shake_cnt_reg;
  logic [15:0]             answer_idx_reg;
  logic                    shaking_reg;
  logic                    valid_reg;
  logic [1:0]              sync_reg;
  logic [DB_W-1:0]         db_cnt_reg;
  logic                    rvalid_reg;
  logic                    err_reg;
  logic [1:0]              rsel_reg;
  logic [ID_WIDTH_OBI-1:0] rid_reg;

  logic        btn_sync;
  logic        hw_trig;
  logic        sw_trig;
  logic        trig;
  logic [1:0]  reg_sel;
  logic        req_err_next;
  logic [31:0] answer_prod;
  logic [31:0] rdata_next;
  logic        unused_bits;

  assign unused_bits = ^{be_i, wdata_i, addr_i[31:4], addr_i[1:0], prn_i[31:16]};

  // Button synchronizer and debounce; counter saturates so one hold gives one trigger
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_reg   <= '0;
      db_cnt_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], button_i};
      if (!btn_sync) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg != DB_FULL) begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  assign btn_sync = sync_reg[1];
  assign hw_trig  = btn_sync && (db_cnt_reg == DB_LAST);

  // OBI request decode
  assign gnt_o        = req_i;
  assign reg_sel      = addr_i[3:2];
  assign sw_trig      = req_i && we_i && (reg_sel == 2'd0);
  assign req_err_next = (reg_sel == 2'd3) || ((reg_sel == 2'd0) ? !we_i : we_i);
  assign trig         = hw_trig | sw_trig;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rsel_reg   <= 2'd0;
      rid_reg    <= '0;
    end else begin
      rvalid_reg <= req_i;
      if (req_i) begin
        err_reg  <= req_err_next;
        rsel_reg <= reg_sel;
        rid_reg  <= aid_i;
      end
    end
  end

  // Read data is taken from live register state in the response cycle
  always_comb begin
    rdata_next = '0;
    if (rvalid_reg && !err_reg) begin
      case (rsel_reg)
        2'd1:    rdata_next = {shake_cnt_reg, 13'd0, btn_sync, state_reg};
        2'd2:    rdata_next = {valid_reg, 15'd0, answer_idx_reg};
        default: rdata_next = '0;
      endcase
    end
  end

  assign rvalid_o = rvalid_reg;
  assign rdata_o  = rdata_next;
  assign err_o    = rvalid_reg & err_reg;
  assign rid_o    = rid_reg;

  // Scaling the low PRN half by NUM_ANSWERS keeps the top 16 bits below NUM_ANSWERS
  assign answer_prod = 32'(prn_i[15:0]) * 32'(NUM_ANSWERS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      shake_cnt_reg  <= '0;
      answer_idx_reg <= '0;
      shaking_reg    <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (trig) begin
            state_reg     <= ST_SHAKE;
            phase_reg     <= '0;
            shake_cnt_reg <= shake_cnt_reg + 16'd1;
            shaking_reg   <= 1'b1;
          end
        end
        ST_SHAKE: begin
          if (phase_reg == SHAKE_LAST) begin
            state_reg   <= ST_REVEAL;
            phase_reg   <= '0;
            shaking_reg <= 1'b0;
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        ST_REVEAL: begin
          answer_idx_reg <= answer_prod[31:16];
          state_reg      <= ST_HOLD;
          phase_reg      <= '0;
          valid_reg      <= 1'b1;
        end
        ST_HOLD: begin
          if (trig) begin
            state_reg     <= ST_SHAKE;
            phase_reg     <= '0;
            shake_cnt_reg <= shake_cnt_reg + 16'd1;
            shaking_reg   <= 1'b1;
            valid_reg     <= 1'b0;
          end else if (phase_reg == HOLD_LAST) begin
            state_reg <= ST_IDLE;
            phase_reg <= '0;
            valid_reg <= 1'b0;
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          shaking_reg <= 1'b0;
          valid_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign shaking_o      = shaking_reg;
  assign answer_valid_o = valid_reg;
  assign answer_idx_o   = answer_idx_reg;

endmodule
